shift_seq_ctrl: RTL
===================

// Module: shift_seq_ctrl
// PURPOSE
//  Sequencer for the 32-bit load/shift-left/shift-right/hold register. It drives the register's S/SL/SR/D inputs.
//  One START command becomes: one parallel load, then AMT single-bit shifts.
//  Shifts are logical, rotate or arithmetic, left or right; result is read back on Q_FB.
//  Sits between the datapath control unit and the shift register.
// PARAMETERS
//  WIDTH  32  data width of the controlled shift register
//  CW     6   shift counter width; must hold WIDTH (clog2(WIDTH+1))
// PORTS
//  CLK    in   1      clock; all state on rising edge
//  RST    in   1      reset, asynchronous, active-low (0 = reset)
//  START  in   1      command strobe; sampled only in IDLE
//  DIR    in   1      0 = shift left (toward MSB), 1 = shift right
//  MODE   in   2      00 logical, 01 rotate, 10 arithmetic, 11 illegal
//  AMT    in   CW     shift amount, legal 0..WIDTH
//  D_IN   in   WIDTH  operand to load
//  ABORT  in   1      cancel an active command
//  Q_FB   in   WIDTH  shift register Q, fed back
//  S      out  2      register op: 11 load, 10 shift left, 01 shift right, 00 hold
//  SL     out  1      bit entering LSB on shift left
//  SR     out  1      bit entering MSB on shift right
//  D_OUT  out  WIDTH  register D input
//  BUSY   out  1      high in LOAD and SHIFT
//  DONE   out  1      one-cycle pulse; result valid on Q_FB
//  ERR    out  1      one-cycle pulse; illegal command rejected
// BEHAVIOUR
//  One clock; reset is asynchronous and active-low.
//  Reset (RST=0, any state, mid-command included):
//   state=IDLE, cnt=0; S=00, SL=0, SR=0, D_OUT=0, BUSY=0, DONE=0, ERR=0.
//   The register is not cleared by this block.
//  FSM states: IDLE, LOAD, SHIFT, FIN, REJ.
//  Outputs decode from registered state and latched command; SL/SR also use Q_FB.
//  IDLE: S=00. On START, latch DIR/MODE/AMT/D_IN.
//   MODE=11 or AMT>WIDTH -> REJ; otherwise -> LOAD.
//  REJ: ERR=1 for one cycle, S=00, register untouched -> IDLE.
//  LOAD: S=11, D_OUT=latched D_IN, BUSY=1, cnt<=latched AMT.
//   AMT=0 -> FIN; otherwise -> SHIFT.
//  SHIFT: S=10 (DIR=0) or 01 (DIR=1), BUSY=1; cnt decrements each cycle.
//   cnt==1 -> FIN. Exactly AMT SHIFT cycles.
//  FIN: S=00, DONE=1 for one cycle -> IDLE. START in FIN is ignored.
//  Fill bits (combinational):
//   left:  SL = Q_FB[WIDTH-1] if rotate, else 0 (logical and arithmetic).
//   right: SR = 0 logical, Q_FB[0] rotate, Q_FB[WIDTH-1] arithmetic.
//   SL=0 when not shifting left; SR=0 when not shifting right.
//  Latency: START accepted at edge k -> LOAD cycle k+1, SHIFT cycles k+2..k+1+AMT.
//   DONE is high in cycle k+2+AMT; Q_FB holds the result in that cycle.
//  START while BUSY, FIN or REJ: ignored, no queueing.
//   The latched command is stable while BUSY regardless of input changes.
//  ABORT in LOAD or SHIFT -> IDLE next edge: S=00, no DONE, no ERR, register holds partial value.
//   ABORT in IDLE is ignored; ABORT and START together in IDLE -> START wins.
//  AMT=WIDTH is legal: logical yields 0, rotate yields the original value.
// TESTING
//  Reset mid-SHIFT (RST=0) -> all outputs 0/IDLE asynchronously; START after release works.
//  D_IN=0x000000F1, DIR=0, MODE=00, AMT=4 -> S: 11,10x4,00; DONE at cycle k+6; Q_FB=0x00000F10.
//  D_IN=0x12345678, DIR=1, MODE=01, AMT=8 -> Q_FB=0x78123456 at DONE.
//  D_IN=0x80000000, DIR=1, MODE=10, AMT=4 -> 0xF8000000; AMT=0 -> DONE at k+2, Q_FB=D_IN.
//  AMT=33 or MODE=11 -> ERR pulse at k+1, S stays 00, BUSY stays 0, no DONE.
//  ABORT at the 2nd SHIFT cycle of AMT=10 -> IDLE, no DONE; START during BUSY -> ignored.
//  Bench uses a cycle model of the shift register driven by S/SL/SR/D_OUT.

Source files
------------

// File: rtl/shift_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : shift_seq_ctrl
// Purpose  : Sequencer for a load/shift-left/shift-right/hold register.
//            Each accepted start command produces one parallel load followed
//            by amt single-bit shifts. The shifts can be logical, rotate or
//            arithmetic, and can go left or right. The result is read back on
//            q_fb.
// Ports    : clk, rst_n        clock, asynchronous active-low reset
//            start             command strobe (sampled only in IDLE)
//            dir               0 = left (toward MSB), 1 = right
//            mode              00 logical, 01 rotate, 10 arithmetic, 11 illegal
//            amt               shift amount, legal range 0..WIDTH
//            d_in              operand to load
//            abort             cancels an active command
//            q_fb              register Q, fed back
//            s                 register op: 11 load, 10 left, 01 right, 00 hold
//            sl, sr            fill bits for the LSB / MSB
//            d_out             register D input
//            busy, done, err   status (done and err are one-cycle pulses)
// Revision : 1.0  initial release
// ============================================================================
module shift_seq_ctrl #(
  parameter int WIDTH = 32,
  parameter int CW    = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             dir,
  input  logic [1:0]       mode,
  input  logic [CW-1:0]    amt,
  input  logic [WIDTH-1:0] d_in,
  input  logic             abort,
  input  logic [WIDTH-1:0] q_fb,
  output logic [1:0]       s,
  output logic             sl,
  output logic             sr,
  output logic [WIDTH-1:0] d_out,
  output logic             busy,
  output logic             done,
  output logic             err
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_SHIFT = 3'd2,
    ST_FIN   = 3'd3,
    ST_REJ   = 3'd4
  } state_t;

  localparam logic [1:0] MODE_ROT   = 2'b01;
  localparam logic [1:0] MODE_ARITH = 2'b10;
  localparam logic [1:0] MODE_ILL   = 2'b11;

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] cnt;
  logic          lat_dir;
  logic [1:0]    lat_mode;
  logic [CW-1:0] lat_amt;

  // Next state. In IDLE the decision uses the live command inputs because
  // they are latched on the same edge. After that, only latched values are
  // used, so changes on the inputs cannot disturb a running command.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (start) begin
          if (mode == MODE_ILL || amt > CW'(WIDTH)) state_nxt = ST_REJ;
          else                                     state_nxt = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (abort)                     state_nxt = ST_IDLE;
        else if (lat_amt == '0)        state_nxt = ST_FIN;
        else                           state_nxt = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (abort)                     state_nxt = ST_IDLE;
        else if (cnt == CW'(1))        state_nxt = ST_FIN;
      end
      ST_FIN:  state_nxt = ST_IDLE;
      ST_REJ:  state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State, counter, latched command and registered outputs. The outputs are
  // decoded from the next state, so they line up with the registered state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      lat_dir  <= 1'b0;
      lat_mode <= 2'b00;
      lat_amt  <= '0;
      s        <= 2'b00;
      d_out    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      state <= state_nxt;

      if (state == ST_IDLE && start) begin
        lat_dir  <= dir;
        lat_mode <= mode;
        lat_amt  <= amt;
      end

      if (state == ST_LOAD)                       cnt <= lat_amt;
      else if (state == ST_SHIFT && cnt != '0)    cnt <= cnt - CW'(1);

      s     <= 2'b00;
      d_out <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      err   <= 1'b0;
      case (state_nxt)
        ST_LOAD: begin
          // LOAD is entered only from IDLE, on the edge that latches d_in
          s     <= 2'b11;
          d_out <= d_in;
          busy  <= 1'b1;
        end
        ST_SHIFT: begin
          s    <= lat_dir ? 2'b01 : 2'b10;
          busy <= 1'b1;
        end
        ST_FIN:  done <= 1'b1;
        ST_REJ:  err  <= 1'b1;
        default: ;
      endcase
    end
  end

  // Fill bits follow the live register contents. They are qualified by the
  // registered op code, so they stay low unless a shift is in progress.
  assign sl = (s == 2'b10) && (lat_mode == MODE_ROT) && q_fb[WIDTH-1];
  assign sr = (s == 2'b01) &&
              (((lat_mode == MODE_ROT)   && q_fb[0]) ||
               ((lat_mode == MODE_ARITH) && q_fb[WIDTH-1]));

  // Only the end bits of the fed-back word determine the fill values
  logic unused_q_mid;
  assign unused_q_mid = ^q_fb[WIDTH-2:1];

endmodule
`default_nettype wire
